// File: rtl/rv32_multicycle_if.sv
// Unified memory port of the multicycle core: one request/ready handshake
// shared by instruction fetch and data access.
interface rv32_multicycle_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_ready_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/rv32_multicycle.sv
// Multicycle RV32I-subset core (lw/sw, add/sub/and/or/slt, addi/andi/ori/slti,
// beq, jal) on a single memory port, with trap/halt and a retire counter.
module rv32_multicycle #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  rv32_multicycle_if.master        mem,
  output logic                     halt_o,
  output logic [1:0]               trap_o,
  output logic [XLEN-1:0]          instret_o
);

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);

  logic [3:0]      r_state;
  logic [XLEN-1:0] r_pc, r_oldpc, r_a, r_b, r_aluout, r_mdr, r_instret;
  logic [31:0]     r_ir;
  logic [1:0]      r_trap;
  logic [XLEN-1:0] r_regs [0:31];

  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_alu_f3_ok, w_is_lw, w_is_sw, w_is_r, w_is_i, w_is_beq, w_is_jal, w_illegal;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_opnd_b, w_alu, w_addr_sum, w_jal_tgt;
  logic            w_rf_we;
  logic [XLEN-1:0] w_rf_wd;

  assign w_op  = r_ir[6:0];
  assign w_f3  = r_ir[14:12];
  assign w_f7  = r_ir[31:25];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_rd  = r_ir[11:7];

  assign w_alu_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b010) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
  assign w_is_lw  = (w_op == OP_LOAD)  && (w_f3 == 3'b010);
  assign w_is_sw  = (w_op == OP_STORE) && (w_f3 == 3'b010);
  assign w_is_r   = (w_op == OP_R) && w_alu_f3_ok &&
                    ((w_f7 == 7'h00) || ((w_f7 == 7'h20) && (w_f3 == 3'b000)));
  assign w_is_i   = (w_op == OP_I) && w_alu_f3_ok;
  assign w_is_beq = (w_op == OP_BR) && (w_f3 == 3'b000);
  assign w_is_jal = (w_op == OP_JAL);
  assign w_illegal = !(w_is_lw || w_is_sw || w_is_r || w_is_i || w_is_beq || w_is_jal);

  assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(XLEN-12){r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-20){r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  assign w_rs1_val  = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val  = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign w_addr_sum = r_a + (w_is_sw ? w_imm_s : w_imm_i);
  assign w_jal_tgt  = r_oldpc + w_imm_j;

  assign halt_o    = (r_state == S_HALT);
  assign trap_o    = r_trap;
  assign instret_o = r_instret;

  // ALU for R-type and I-type arithmetic; funct7[5] selects sub only for R-type
  always_comb begin
    w_opnd_b = w_is_r ? r_b : w_imm_i;
    case (w_f3)
      3'b000:  w_alu = (w_is_r && w_f7[5]) ? (r_a - w_opnd_b) : (r_a + w_opnd_b);
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_opnd_b))};
      3'b110:  w_alu = r_a | w_opnd_b;
      3'b111:  w_alu = r_a & w_opnd_b;
      default: w_alu = '0;
    endcase
  end

  // Memory port driven purely from registered state so ready/rdata never feed back
  always_comb begin
    mem.mem_req_o   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    mem.mem_we_o    = (r_state == S_MEMWR);
    mem.mem_addr_o  = (r_state == S_FETCH) ? r_pc :
                      ((r_state == S_MEMRD) || (r_state == S_MEMWR)) ? r_aluout : '0;
    mem.mem_wdata_o = (r_state == S_MEMWR) ? r_b : '0;
  end

  // Register-file write port: load, ALU and jal link write-back
  always_comb begin
    w_rf_we = 1'b0;
    w_rf_wd = '0;
    case (r_state)
      S_MEMWB: begin w_rf_we = 1'b1; w_rf_wd = r_mdr; end
      S_ALUWB: begin w_rf_we = 1'b1; w_rf_wd = r_aluout; end
      S_JAL:   begin w_rf_we = (w_jal_tgt[1:0] == 2'b00); w_rf_wd = r_pc; end
      default: ;
    endcase
  end

  // Register file storage; x0 is never written
  always_ff @(posedge clk_i) begin
    if (w_rf_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_rf_wd;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_RST;
      r_pc      <= RESET_PC;
      r_oldpc   <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluout  <= '0;
      r_mdr     <= '0;
      r_instret <= '0;
      r_trap    <= 2'd0;
    end else begin
      case (r_state)
        S_RST: r_state <= S_FETCH;
        S_FETCH: if (mem.mem_ready_i) begin
          r_ir    <= mem.mem_rdata_i[31:0];
          r_oldpc <= r_pc;
          r_pc    <= r_pc + PC_STEP;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a      <= w_rs1_val;
          r_b      <= w_rs2_val;
          r_aluout <= r_oldpc + w_imm_b;
          if (w_illegal)                begin r_trap <= 2'd1; r_state <= S_HALT; end
          else if (w_is_lw || w_is_sw)  r_state <= S_MEMADR;
          else if (w_is_r || w_is_i)    r_state <= S_EXEC;
          else if (w_is_beq)            r_state <= S_BEQ;
          else                          r_state <= S_JAL;
        end
        S_MEMADR: begin
          r_aluout <= w_addr_sum;
          if (w_addr_sum[1:0] != 2'b00) begin r_trap <= 2'd2; r_state <= S_HALT; end
          else r_state <= w_is_lw ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: if (mem.mem_ready_i) begin
          r_mdr   <= mem.mem_rdata_i;
          r_state <= S_MEMWB;
        end
        S_MEMWB: begin r_instret <= r_instret + ONE; r_state <= S_FETCH; end
        S_MEMWR: if (mem.mem_ready_i) begin
          r_instret <= r_instret + ONE;
          r_state   <= S_FETCH;
        end
        S_EXEC:  begin r_aluout <= w_alu; r_state <= S_ALUWB; end
        S_ALUWB: begin r_instret <= r_instret + ONE; r_state <= S_FETCH; end
        S_BEQ: begin
          // branch target was precomputed into ALUOut during decode
          if ((r_a == r_b) && (r_aluout[1:0] != 2'b00)) begin
            r_trap  <= 2'd3;
            r_state <= S_HALT;
          end else begin
            if (r_a == r_b) r_pc <= r_aluout;
            r_instret <= r_instret + ONE;
            r_state   <= S_FETCH;
          end
        end
        S_JAL: begin
          if (w_jal_tgt[1:0] != 2'b00) begin
            r_trap  <= 2'd3;
            r_state <= S_HALT;
          end else begin
            r_pc      <= w_jal_tgt;
            r_instret <= r_instret + ONE;
            r_state   <= S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_multicycle.sv
// Bench for rv32_multicycle: ISA-level reference interpreter produces the
// expected memory transaction stream, timing and final state; a memory
// responder with random wait states checks the DUT against it every cycle.
module tb_rv32_multicycle;
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        halt_o;
  logic [1:0]  trap_o;
  logic [31:0] instret_o;

  rv32_multicycle_if #(.XLEN(XLEN)) mif ();

  rv32_multicycle #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mem       (mif),
    .halt_o    (halt_o),
    .trap_o    (trap_o),
    .instret_o (instret_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memories and reference model ----------------
  logic [31:0] tmem [0:1023];
  logic [31:0] mmem [0:1023];

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cpi_prev;
    logic [31:0] ninstret;
  } txn_t;

  txn_t        expq[$];
  logic [31:0] mregs [0:31];
  bit          mwritten [0:31];
  logic [1:0]  exp_trap;
  logic [31:0] exp_instret;

  function automatic void mwr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) begin
      mregs[rd] = v;
      mwritten[rd] = 1'b1;
    end
  endfunction

  function automatic void push_txn(input bit f, input bit we, input logic [31:0] a,
                                   input logic [31:0] d, input int cp, input logic [31:0] n);
    txn_t t;
    t.fetch = f; t.we = we; t.addr = a; t.wdata = d; t.cpi_prev = cp; t.ninstret = n;
    expq.push_back(t);
  endfunction

  function automatic void run_model();
    logic [31:0] pc, ir, a, b, x, y, ea, t, npc, immi, imms, immb, immj;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] ret;
    int          cpi, prev;
    bit          done, alu_ok;
    expq.delete();
    for (int i = 0; i < 32; i++) begin mregs[i] = '0; mwritten[i] = 1'b0; end
    pc = RPC; ret = '0; prev = 0; done = 1'b0; exp_trap = 2'd0;
    for (int step = 0; step < 4000 && !done; step++) begin
      push_txn(1'b1, 1'b0, pc, '0, prev, ret);
      ir = mmem[pc[11:2]];
      op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25]; rd = ir[11:7];
      a = mregs[ir[19:15]]; b = mregs[ir[24:20]];
      immi = {{20{ir[31]}}, ir[31:20]};
      imms = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      immb = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      immj = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      npc = pc + 32'd4; cpi = 0;
      alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
      if (op == 7'h03 && f3 == 3'd2) begin
        ea = a + immi;
        if (ea[1:0] != 2'b00) begin exp_trap = 2'd2; done = 1'b1; end
        else begin push_txn(1'b0, 1'b0, ea, '0, 0, '0); mwr(rd, mmem[ea[11:2]]); cpi = 5; end
      end else if (op == 7'h23 && f3 == 3'd2) begin
        ea = a + imms;
        if (ea[1:0] != 2'b00) begin exp_trap = 2'd2; done = 1'b1; end
        else begin push_txn(1'b0, 1'b1, ea, b, 0, '0); mmem[ea[11:2]] = b; cpi = 4; end
      end else if ((op == 7'h33 && alu_ok && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0))) ||
                   (op == 7'h13 && alu_ok)) begin
        x = a; y = (op == 7'h33) ? b : immi;
        case (f3)
          3'd0:    t = (op == 7'h33 && f7 == 7'h20) ? x - y : x + y;
          3'd2:    t = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          3'd6:    t = x | y;
          default: t = x & y;
        endcase
        mwr(rd, t); cpi = 4;
      end else if (op == 7'h63 && f3 == 3'd0) begin
        t = pc + immb; cpi = 3;
        if (a == b) begin
          if (t[1:0] != 2'b00) begin exp_trap = 2'd3; done = 1'b1; end
          else npc = t;
        end
      end else if (op == 7'h6F) begin
        t = pc + immj; cpi = 3;
        if (t[1:0] != 2'b00) begin exp_trap = 2'd3; done = 1'b1; end
        else begin mwr(rd, pc + 32'd4); npc = t; end
      end else begin
        exp_trap = 2'd1; done = 1'b1;
      end
      if (!done) begin ret = ret + 32'd1; prev = cpi; pc = npc; end
    end
    exp_instret = ret;
  endfunction

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  localparam logic [31:0] ILLEGAL = 32'h0000_007F;
  logic [31:0] emit_pc;

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin tmem[i] = '0; mmem[i] = '0; end
    emit_pc = RPC;
  endtask
  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    tmem[addr[11:2]] = w;
    mmem[addr[11:2]] = w;
  endtask
  task automatic emit(input logic [31:0] w);
    put(emit_pc, w);
    emit_pc = emit_pc + 32'd4;
  endtask

  // ---------------- memory responder / per-cycle compare ----------------
  int          cyc = 0;
  int          maxw = 0;
  bit          stall_data = 1'b0;
  bit          in_req = 1'b0;
  int          waits_left = 0, cur_w = 0, data_w = 0, last_fetch_cyc = 0;
  logic [31:0] cap_addr, cap_wdata, last_fetch_addr;
  logic        cap_we;
  bit          saw_store = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    txn_t tx;
    mif.mem_ready_i = 1'b0;
    mif.mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        mif.mem_ready_i = 1'b0;
        in_req = 1'b0;
      end else begin
        if (!halt_o) check("trap_idle", {30'd0, trap_o}, 32'd0);
        if (mif.mem_req_o) begin
          if (!in_req || mif.mem_ready_i) begin
            in_req = 1'b1;
            cur_w = $urandom_range(0, maxw);
            if (stall_data && expq.size() > 0 && !expq[0].fetch && !expq[0].we) cur_w = 100000;
            waits_left = cur_w;
            cap_addr = mif.mem_addr_o; cap_we = mif.mem_we_o; cap_wdata = mif.mem_wdata_o;
          end else begin
            check("stall_addr", mif.mem_addr_o, cap_addr);
            check("stall_we", {31'd0, mif.mem_we_o}, {31'd0, cap_we});
            if (cap_we) check("stall_wdata", mif.mem_wdata_o, cap_wdata);
          end
          if (waits_left == 0) begin
            mif.mem_ready_i = 1'b1;
            mif.mem_rdata_i = tmem[mif.mem_addr_o[11:2]];
            checks++;
            if (expq.size() == 0) begin
              errors++;
              $display("FAIL extra_req actual=%h required=none", mif.mem_addr_o);
            end else begin
              tx = expq.pop_front();
              check("txn_addr", mif.mem_addr_o, tx.addr);
              check("txn_we", {31'd0, mif.mem_we_o}, {31'd0, tx.we});
              if (tx.we) check("txn_wdata", mif.mem_wdata_o, tx.wdata);
              if (tx.fetch) begin
                check("fetch_instret", instret_o, tx.ninstret);
                if (tx.cpi_prev > 0)
                  check("fetch_timing", cyc, last_fetch_cyc + tx.cpi_prev + data_w + cur_w);
                last_fetch_cyc = cyc;
                last_fetch_addr = mif.mem_addr_o;
                data_w = 0;
              end else begin
                data_w = cur_w;
              end
            end
            if (mif.mem_we_o) begin
              tmem[mif.mem_addr_o[11:2]] = mif.mem_wdata_o;
              if (mif.mem_addr_o == 32'h40 && mif.mem_wdata_o == 32'd2) saw_store = 1'b1;
            end
          end else begin
            mif.mem_ready_i = 1'b0;
            waits_left--;
          end
        end else begin
          mif.mem_ready_i = 1'b0;
          in_req = 1'b0;
        end
      end
    end
  end

  // ---------------- test sequencing ----------------
  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("rst_req", {31'd0, mif.mem_req_o}, 32'd0);
    check("rst_we", {31'd0, mif.mem_we_o}, 32'd0);
    check("rst_addr", mif.mem_addr_o, 32'd0);
    check("rst_wdata", mif.mem_wdata_o, 32'd0);
    check("rst_halt", {31'd0, halt_o}, 32'd0);
    check("rst_trap", {30'd0, trap_o}, 32'd0);
    check("rst_instret", instret_o, 32'd0);
    repeat (2) begin
      @(negedge clk_i);
      check("rst_instret_hold", instret_o, 32'd0);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rel_req_low", {31'd0, mif.mem_req_o}, 32'd0);
    @(negedge clk_i);
    check("first_req", {31'd0, mif.mem_req_o}, 32'd1);
    check("first_addr", mif.mem_addr_o, RPC);
    check("first_we", {31'd0, mif.mem_we_o}, 32'd0);
  endtask

  task automatic run_prog(input int w);
    bit any_req;
    maxw = w;
    run_model();
    do_reset();
    for (int i = 0; i < 5000 && !halt_o; i++) @(negedge clk_i);
    check("halt_reached", {31'd0, halt_o}, 32'd1);
    check("halt_trap", {30'd0, trap_o}, {30'd0, exp_trap});
    check("halt_instret", instret_o, exp_instret);
    check("txn_left", expq.size(), 32'd0);
    for (int i = 1; i < 32; i++)
      if (mwritten[i]) check($sformatf("reg_x%0d", i), dut.r_regs[i], mregs[i]);
    any_req = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      if (mif.mem_req_o) any_req = 1'b1;
    end
    check("req_after_halt", {31'd0, any_req}, 32'd0);
  endtask

  initial begin
    logic [31:0] r32;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    bit          found;

    // A: ALU program, zero wait states
    clear_mem();
    emit(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5));
    emit(enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'hFFD));
    emit(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    emit(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd4));
    emit(enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd0));
    emit(ILLEGAL);
    run_prog(0);
    check("A_x3", dut.r_regs[3], 32'd2);
    check("A_x4", dut.r_regs[4], 32'd1);
    check("A_instret", instret_o, 32'd5);
    check("A_trap", {30'd0, trap_o}, 32'd1);

    // B: store then load with random wait states
    clear_mem();
    saw_store = 1'b0;
    emit(enc_i(7'h13, 3'd0, 5'd3, 5'd0, 12'd2));
    emit(enc_s(5'd3, 5'd0, 12'h040));
    emit(enc_i(7'h03, 3'd2, 5'd5, 5'd0, 12'h040));
    emit(ILLEGAL);
    run_prog(4);
    check("B_x5", dut.r_regs[5], 32'd2);
    check("B_store_seen", {31'd0, saw_store}, 32'd1);

    // C: beq loop (3 iterations) then jal chain through 0x20
    clear_mem();
    emit(enc_i(7'h13, 3'd0, 5'd3, 5'd0, 12'd3));
    emit(enc_i(7'h13, 3'd0, 5'd6, 5'd0, 12'd1));
    emit(enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'd0));
    emit(enc_i(7'h13, 3'd0, 5'd2, 5'd2, 12'd1));
    emit(enc_r(7'h00, 5'd3, 5'd2, 3'd2, 5'd4));
    emit(enc_b(5'd4, 5'd6, 13'h1FF8));
    emit(enc_j(5'd0, 21'h1FFF08));
    put(32'h20, enc_j(5'd1, 21'h00000C));
    put(32'h2C, ILLEGAL);
    run_prog(2);
    check("C_x2", dut.r_regs[2], 32'd3);
    check("C_x1", dut.r_regs[1], 32'h24);
    check("C_last_fetch", last_fetch_addr, 32'h2C);
    check("C_instret", instret_o, 32'd14);

    // D1: illegal opcode
    clear_mem();
    emit(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd1));
    emit(ILLEGAL);
    run_prog(1);
    check("D1_trap", {30'd0, trap_o}, 32'd1);
    check("D1_instret", instret_o, 32'd1);

    // D2: misaligned load address
    clear_mem();
    emit(enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'd7));
    emit(enc_i(7'h03, 3'd2, 5'd5, 5'd0, 12'h042));
    run_prog(2);
    check("D2_trap", {30'd0, trap_o}, 32'd2);
    check("D2_instret", instret_o, 32'd1);
    check("D2_x5", dut.r_regs[5], 32'd7);

    // D3: jal to PC+2
    clear_mem();
    emit(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd9));
    emit(enc_j(5'd1, 21'h000002));
    run_prog(2);
    check("D3_trap", {30'd0, trap_o}, 32'd3);
    check("D3_instret", instret_o, 32'd1);
    check("D3_x1", dut.r_regs[1], 32'd9);

    // E: random ALU programs, results stored to memory
    for (int p = 0; p < 4; p++) begin
      clear_mem();
      for (int i = 1; i < 8; i++) begin
        r32 = $urandom(); imm = r32[11:0];
        r32 = i; rd = r32[4:0];
        emit(enc_i(7'h13, 3'd0, rd, 5'd0, imm));
      end
      for (int i = 0; i < 14; i++) begin
        r32 = $urandom_range(0, 7); rd  = r32[4:0];
        r32 = $urandom_range(0, 7); rs1 = r32[4:0];
        r32 = $urandom_range(0, 7); rs2 = r32[4:0];
        r32 = $urandom(); imm = r32[11:0];
        case ($urandom_range(0, 8))
          0: emit(enc_r(7'h00, rs2, rs1, 3'd0, rd));
          1: emit(enc_r(7'h20, rs2, rs1, 3'd0, rd));
          2: emit(enc_r(7'h00, rs2, rs1, 3'd7, rd));
          3: emit(enc_r(7'h00, rs2, rs1, 3'd6, rd));
          4: emit(enc_r(7'h00, rs2, rs1, 3'd2, rd));
          5: emit(enc_i(7'h13, 3'd0, rd, rs1, imm));
          6: emit(enc_i(7'h13, 3'd7, rd, rs1, imm));
          7: emit(enc_i(7'h13, 3'd6, rd, rs1, imm));
          default: emit(enc_i(7'h13, 3'd2, rd, rs1, imm));
        endcase
      end
      for (int i = 1; i < 8; i++) begin
        r32 = 32'h200 + 32'(i) * 32'd4; imm = r32[11:0];
        r32 = i; rs2 = r32[4:0];
        emit(enc_s(rs2, 5'd0, imm));
      end
      emit(ILLEGAL);
      run_prog(3);
    end

    // F: asynchronous reset while a load is stalled
    clear_mem();
    put(32'h40, 32'h55);
    emit(enc_i(7'h13, 3'd0, 5'd7, 5'd0, 12'h011));
    emit(enc_i(7'h03, 3'd2, 5'd7, 5'd0, 12'h040));
    emit(ILLEGAL);
    stall_data = 1'b1;
    maxw = 1;
    run_model();
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_i);
      if (mif.mem_req_o && !mif.mem_we_o && mif.mem_addr_o == 32'h40) found = 1'b1;
    end
    check("F_lw_seen", {31'd0, found}, 32'd1);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("F_req_drop", {31'd0, mif.mem_req_o}, 32'd0);
    check("F_pc", dut.r_pc, RPC);
    check("F_instret", instret_o, 32'd0);
    @(negedge clk_i);
    check("F_x7", dut.r_regs[7], 32'h11);
    stall_data = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
